// File: rtl/deser_pkg.sv
// deser_pkg: shared constants and state encoding for the serial-to-parallel
// word assembler.
//   WORD_W    - assembled word width (only 32 is supported)
//   FRAME_LEN - serial bits per frame (WORD_W, or WORD_W+1 with parity)
//   CNT_W     - bit counter width
//   state_t   - RECV (collecting bits) / HOLD (word presented)
// Build option: DESER_PARITY_EN appends one even-parity bit per frame.
package deser_pkg;

    localparam int WORD_W = 32;
`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = WORD_W + 1;
`else
    localparam int FRAME_LEN = WORD_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: shift register with per-frame bit-order select.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   shift_en  - shift sin in this cycle
//   first     - this shift is the first bit of a frame (latch rev now)
//   rev       - 0: bits enter at the top and move down (first bit ends at sr[0])
//               1: bits enter at the bottom and move up (first bit ends at sr[MSB])
//   sin       - serial bit
//   sr        - current register contents
//   sr_nxt    - contents after this cycle's shift (lets the top capture a
//               word whose last bit arrives this cycle)
module deser_shift_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              first,
    input  logic              rev,
    input  logic              sin,
    output logic [WORD_W-1:0] sr,
    output logic [WORD_W-1:0] sr_nxt
);

    logic dir_q;
    logic dir;

    // On the first bit the live rev input decides; afterwards the latched
    // copy does, so rev toggling mid-frame has no effect.
    assign dir = first ? rev : dir_q;

    always_comb begin
        sr_nxt = sr;
        if (shift_en)
            sr_nxt = dir ? {sr[WORD_W-2:0], sin} : {sin, sr[WORD_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            dir_q <= 1'b0;
        end else begin
            sr <= sr_nxt;
            if (first)
                dir_q <= rev;
        end
    end

endmodule

// File: rtl/deserialize_32bit.sv
// deserialize_32bit: collects a serial bit stream into 32-bit words with a
// valid/ready handshake on both sides.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   sin, sin_valid        - serial input bit and its valid
//   sin_ready             - high while collecting (RECV)
//   rev                   - bit order, sampled on the first bit of each frame
//   out, out_valid        - assembled word, held until out_ready
//   out_ready             - consumer accepts the word
//   parity_err            - even-parity failure for the presented word
// Build option: DESER_PARITY_EN -> 33-bit frames, last bit is even parity
// (not stored); without it parity_err is tied low.
module deserialize_32bit
    import deser_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    output logic              sin_ready,
    input  logic              rev,
    output logic [WORD_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              first;
    logic              last;
    logic              shift_en;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_nxt;

    assign sin_ready = (state == RECV);
    assign accept    = sin_valid && sin_ready;
    assign first     = accept && (cnt == '0);
    assign last      = (cnt == CNT_W'(FRAME_LEN - 1));

`ifdef DESER_PARITY_EN
    // The trailing parity bit is checked but never shifted into the word.
    assign shift_en = accept && !last;
`else
    assign shift_en = accept;
`endif

    deser_shift_reg #(.WORD_W(WORD_W)) u_sr (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .first    (first),
        .rev      (rev),
        .sin      (sin),
        .sr       (sr),
        .sr_nxt   (sr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RECV;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (accept) begin
                        if (last) begin
                            state     <= HOLD;
                            cnt       <= '0;
                            out       <= sr_nxt;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // out keeps the delivered word until the next one completes
                    if (out_ready) begin
                        state     <= RECV;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

`ifdef DESER_PARITY_EN
    logic par;  // running XOR of the frame's bits so far

    always_ff @(posedge clk) begin
        if (rst) begin
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else if (accept) begin
            if (last) begin
                parity_err <= par ^ sin;
                par        <= 1'b0;
            end else begin
                par <= par ^ sin;
            end
        end else if (state == HOLD && out_ready) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/deserialize_32bit.md
DESERIALIZE_32BIT -- requirements
Module: deserialize_32bit

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning data word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sin  input  1  serial data bit.
REQ-005 SHALL have port sin_valid  input  1  sin carries a bit this cycle.
REQ-006 SHALL have port sin_ready  output  1  block accepts a bit this cycle.
REQ-007 SHALL have port rev  input  1  bit order: 0 = first bit to out[0]; 1 = first bit to out[31].
REQ-008 SHALL have port out  output  32  assembled word.
REQ-009 SHALL have port out_valid  output  1  out holds a complete word.
REQ-010 SHALL have port out_ready  input  1  consumer takes word.
REQ-011 SHALL have port parity_err  output  1  parity failure flag for the current word.

Function
REQ-012 SHALL implement two states: RECV (collecting bits, sin_ready=1) and HOLD (word presented, sin_ready=0).
REQ-013 SHALL accept a bit only on a cycle where sin_valid && sin_ready.
REQ-014 SHALL sample rev on the frame's first accepted bit and use that value for the whole frame; rev changes mid-frame SHALL be ignored.
REQ-015 SHALL shift with rev=0 as sr <= {sin, sr[31:1]}, and with rev=1 as sr <= {sr[30:0], sin}.
REQ-016 SHALL keep a bit counter of 0..FRAME_LEN-1; the counter holds on idle cycles (sin_valid=0).
REQ-017 SHALL go RECV->HOLD on acceptance of the last frame bit, with out updated and out_valid=1 on the next cycle (1-cycle latency).
REQ-018 SHALL hold out and out_valid stable in HOLD until out_ready=1, then return to RECV on the next cycle with the counter at 0.
REQ-019 SHALL complete the transfer if out_ready=1 on the first HOLD cycle; minimum period SHALL be FRAME_LEN+1 cycles per word.
REQ-020 SHALL keep out at the last delivered word after the handshake until the next word completes.
REQ-021 SHALL treat gaps of any length between bits within a frame as legal.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set state=RECV, counter=0, sr=0, out=0, out_valid=0, and parity_err=0; sin_ready SHALL be 1 in the first cycle after reset.
REQ-023 SHALL discard a partial frame or held word on reset mid-operation; no word is emitted.
REQ-024 SHALL give rst priority over all other inputs in the same cycle.

Configuration
REQ-025 SHALL, with DESER_PARITY_EN defined, use FRAME_LEN=33, where bit 33 is even parity and is not stored in out.
REQ-026 SHALL, in that mode, set parity_err=1 with out_valid if the XOR of all 33 bits is 1; parity_err SHALL be cleared on the handshake.
REQ-027 SHALL, with DESER_PARITY_EN undefined, use FRAME_LEN=32 and tie parity_err to 0; port lists SHALL be identical in both builds.

Structure
REQ-028 SHALL place WORD_W, the counter width, and the state encoding (RECV, HOLD) in package deser_pkg.
REQ-029 SHALL place the shift register plus rev-latched direction select in sub-module deser_shift_reg; the FSM, counter, and parity logic SHALL stay in the top module.

Verification
REQ-030 SHALL verify: rev=0, send 32 bits of 0x12345678 LSB-first -> out=0x12345678 with out_valid=1 one cycle after the last bit.
REQ-031 SHALL verify: rev=1, send 32 bits of 0xA5A5_0F0F MSB-first -> out=0xA5A50F0F; toggling rev after bit 5 does not change the result.
REQ-032 SHALL verify: out_ready=0 for 10 cycles in HOLD -> out stable, sin_ready=0, and bits driven meanwhile are not consumed; out_ready=1 -> sin_ready=1 next cycle.
REQ-033 SHALL verify: rst asserted after 17 bits, then a full word 0xDEADBEEF -> exactly one out_valid, with out=0xDEADBEEF.
REQ-034 SHALL verify: random sin_valid gaps (0-5 cycles) over 100 words -> all words match the model.
REQ-035 SHALL verify, with DESER_PARITY_EN: word 0x00000001 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
